// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if
//   Bundles the ID/EX-to-multiply/divide handshake and data signals.
//   The master side (ID/EX register) presents an op and its operands.
//   The slave side (ex_muldiv) returns stall, a done strobe, the result
//   and its destination register.
//
//   master -> slave : start_i, flush_i, op_i, rs1_data_i, rs2_data_i, rd_i
//   slave -> master : stall_o, done_o, result_o, rd_o
interface ex_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
);
  logic                  start_i;
  logic                  flush_i;
  logic [2:0]            op_i;
  logic [DATA_WIDTH-1:0] rs1_data_i;
  logic [DATA_WIDTH-1:0] rs2_data_i;
  logic [RD_WIDTH-1:0]   rd_i;
  logic                  stall_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;
  logic [RD_WIDTH-1:0]   rd_o;

  modport master (
    output start_i, flush_i, op_i, rs1_data_i, rs2_data_i, rd_i,
    input  stall_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, flush_i, op_i, rs1_data_i, rs2_data_i, rd_i,
    output stall_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv
//   Iterative RV32M multiply/divide unit sitting behind the ID/EX register.
//   Multiplies by shift-add and divides by restoring shift-subtract, both
//   on operand magnitudes, one bit per cycle for DATA_WIDTH cycles; the
//   sign is restored when the result is captured. Divide-by-zero and the
//   signed-overflow divide finish one cycle after accept with the
//   architecturally defined values.
//
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : ex_muldiv_if.slave
//            start_i    ID/EX holds a valid M op
//            flush_i    kill any in-flight op (priority over start_i)
//            op_i       funct3 (MUL..REMU)
//            rs1_data_i dividend / multiplicand
//            rs2_data_i divisor / multiplier
//            rd_i       destination register
//            stall_o    hold PC, IF/ID and ID/EX (combinational)
//            done_o     one-cycle result-valid strobe
//            result_o   result, held until the next completion
//            rd_o       destination register of result_o
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5,
  parameter int CNT_WIDTH  = 6
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES_W   = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negate of a single-width word.
  function automatic logic [DATA_WIDTH-1:0] neg_w(input logic [DATA_WIDTH-1:0] x);
    return ~x + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negate of a double-width product.
  function automatic logic [2*DATA_WIDTH-1:0] neg_dw(input logic [2*DATA_WIDTH-1:0] x);
    return ~x + {{(2*DATA_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t                state;
  state_t                state_nxt;
  logic [CNT_WIDTH-1:0]  count;
  logic [2:0]            op;
  logic                  neg1;
  logic                  neg2;
  // Multiply: opnd = multiplicand, acc_hi:acc_lo = partial product / multiplier.
  // Divide:   opnd = divisor,      acc_hi = remainder, acc_lo = dividend/quotient.
  logic [DATA_WIDTH-1:0] opnd;
  logic [DATA_WIDTH-1:0] acc_hi;
  logic [DATA_WIDTH-1:0] acc_lo;
  logic [RD_WIDTH-1:0]   rd_pend;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic [RD_WIDTH-1:0]   rd_res;

  logic                  accept;
  logic                  last;
  logic                  rs1_signed;
  logic                  rs2_signed;
  logic                  in_neg1;
  logic                  in_neg2;
  logic [DATA_WIDTH-1:0] in_mag1;
  logic [DATA_WIDTH-1:0] in_mag2;
  logic                  div_zero;
  logic                  div_ovf;
  logic                  fast;
  logic [DATA_WIDTH-1:0] fast_result;

  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     div_shift;
  logic [DATA_WIDTH:0]     div_diff;
  logic [DATA_WIDTH-1:0]   step_hi;
  logic [DATA_WIDTH-1:0]   step_lo;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   quo_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;
  logic [DATA_WIDTH-1:0]   calc_result;

  assign accept = bus.start_i && !bus.flush_i && ((state == IDLE) || (state == DONE));
  assign last   = (state == CALC) && (count == CNT_LAST);

  assign bus.stall_o  = accept || (state == CALC);
  assign bus.done_o   = done;
  assign bus.result_o = result;
  assign bus.rd_o     = rd_res;

  // Decode the incoming op: operand signedness, magnitudes and the one-cycle special cases.
  always_comb begin
    rs1_signed  = 1'b0;
    rs2_signed  = 1'b0;
    fast_result = ZERO_W;
    case (bus.op_i)
      OP_MULH, OP_DIV, OP_REM: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b1;
      end
      OP_MULHSU: begin
        rs1_signed = 1'b1;
        rs2_signed = 1'b0;
      end
      default: begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
      end
    endcase

    in_neg1 = rs1_signed && bus.rs1_data_i[DATA_WIDTH-1];
    in_neg2 = rs2_signed && bus.rs2_data_i[DATA_WIDTH-1];
    in_mag1 = in_neg1 ? neg_w(bus.rs1_data_i) : bus.rs1_data_i;
    in_mag2 = in_neg2 ? neg_w(bus.rs2_data_i) : bus.rs2_data_i;

    div_zero = (bus.rs2_data_i == ZERO_W);
    // Only the signed divides (funct3 bit0 clear) can overflow.
    div_ovf  = !bus.op_i[0] && (bus.rs1_data_i == MIN_NEG) && (bus.rs2_data_i == ONES_W);
    fast     = bus.op_i[2] && (div_zero || div_ovf);

    case (bus.op_i)
      OP_DIV, OP_DIVU: fast_result = div_zero ? ONES_W : MIN_NEG;
      OP_REM, OP_REMU: fast_result = div_zero ? bus.rs1_data_i : ZERO_W;
      default:         fast_result = ZERO_W;
    endcase
  end

  // One iteration of shift-add (multiply) or restoring shift-subtract (divide).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {1'b0, ZERO_W});
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (op[2]) begin
      // A carry-out in the shifted remainder guarantees the subtraction fits.
      if (!div_diff[DATA_WIDTH] || div_shift[DATA_WIDTH]) begin
        step_hi = div_diff[DATA_WIDTH-1:0];
        step_lo = {acc_lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[DATA_WIDTH-1:0];
        step_lo = {acc_lo[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[DATA_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
    end
  end

  // Restore signs on the final iteration's output and pick the op's result.
  always_comb begin
    prod_fix    = (neg1 ^ neg2) ? neg_dw({step_hi, step_lo}) : {step_hi, step_lo};
    quo_fix     = (neg1 ^ neg2) ? neg_w(step_lo) : step_lo;
    rem_fix     = neg1 ? neg_w(step_hi) : step_hi;
    calc_result = ZERO_W;
    case (op)
      OP_MUL:                       calc_result = prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              calc_result = quo_fix;
      OP_REM, OP_REMU:              calc_result = rem_fix;
      default:                      calc_result = ZERO_W;
    endcase
  end

  // FSM next-state: flush wins everywhere, a new op may start straight out of DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.flush_i) begin
          state_nxt = IDLE;
        end else if (bus.start_i) begin
          state_nxt = fast ? DONE : CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = CALC;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture, iteration datapath and result/done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= CNT_ZERO;
      op      <= 3'd0;
      neg1    <= 1'b0;
      neg2    <= 1'b0;
      opnd    <= ZERO_W;
      acc_hi  <= ZERO_W;
      acc_lo  <= ZERO_W;
      rd_pend <= {RD_WIDTH{1'b0}};
      done    <= 1'b0;
      result  <= ZERO_W;
      rd_res  <= {RD_WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      if (bus.flush_i) begin
        // result/rd_res intentionally keep the last completed op.
        count <= CNT_ZERO;
      end else if (accept) begin
        count   <= CNT_ZERO;
        op      <= bus.op_i;
        rd_pend <= bus.rd_i;
        // Plain MUL leaves both flags clear: the low half is sign-agnostic.
        neg1    <= in_neg1;
        neg2    <= in_neg2;
        opnd    <= bus.op_i[2] ? in_mag2 : in_mag1;
        acc_hi  <= ZERO_W;
        acc_lo  <= bus.op_i[2] ? in_mag1 : in_mag2;
        if (fast) begin
          result <= fast_result;
          rd_res <= bus.rd_i;
          done   <= 1'b1;
        end
      end else if (state == CALC) begin
        acc_hi <= step_hi;
        acc_lo <= step_lo;
        if (last) begin
          count  <= CNT_ZERO;
          result <= calc_result;
          rd_res <= rd_pend;
          done   <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end else begin
        count <= CNT_ZERO;
      end
    end
  end

endmodule
